// File: rtl/sigma_delta_mux_scheduler_pkg.sv
// Shared types and helpers for the sigma-delta mux scheduler.
// The scheduler state encoding and the round-robin index wrap live here.
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SETTLE,
    ACCUM
  } sd_sched_state_t;

  // Wraps ptr+offset back into 0..n-1; offset never exceeds n.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/sigma_delta_mux_scheduler_if.sv
// Control, ADC-side and result-side signals of the mux scheduler.
// The slave modport is the scheduler; master is whoever feeds and drains it.
interface sigma_delta_mux_scheduler_if #(
  parameter int NUM_CH   = 4,
  parameter int ADC_WDTH = 16,
  parameter int CH_WDTH  = $clog2(NUM_CH)
);
  logic                en;
  logic [NUM_CH-1:0]   ch_mask;
  logic [ADC_WDTH-1:0] adc_output;
  logic                adc_valid;
  logic [CH_WDTH-1:0]  mux_sel;
  logic [ADC_WDTH-1:0] out_data;
  logic [CH_WDTH-1:0]  out_ch;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
  logic                busy;

  modport master (
    output en, ch_mask, adc_output, adc_valid, out_ready,
    input  mux_sel, out_data, out_ch, out_valid, overrun, busy
  );

  modport slave (
    input  en, ch_mask, adc_output, adc_valid, out_ready,
    output mux_sel, out_data, out_ch, out_valid, overrun, busy
  );
endinterface

// File: rtl/sigma_delta_mux_scheduler_rr_pick.sv
// Combinational round-robin picker: first set mask bit after ptr, wrapping,
// with ptr itself checked last so a lone enabled channel is re-picked.
module sd_rr_pick
  import sigma_delta_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_WDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  mask,
  input  logic [CH_WDTH-1:0] ptr,
  output logic [CH_WDTH-1:0] pick,
  output logic               found
);

  logic [CH_WDTH-1:0] cand;

  // Walk from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_WDTH'(rr_wrap(int'(ptr) + k, NUM_CH));
      if (mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigma_delta_mux_scheduler.sv
// Time-shares one sigma-delta ADC across NUM_CH muxed inputs: round-robin select,
// discard settling samples, average 2**AVG_LOG2 samples, emit channel-tagged result.
module sigma_delta_mux_scheduler
  import sigma_delta_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADC_WDTH = 16,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2,
  parameter int CH_WDTH  = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  sigma_delta_mux_scheduler_if.slave bus
);

  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int ACC_W  = ADC_WDTH + AVG_LOG2;
  localparam int SCNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam int ACNT_W = AVG_LOG2 + 1;

  sd_sched_state_t     state;
  logic [CH_WDTH-1:0]  ptr;
  logic [CH_WDTH-1:0]  mux_sel_q;
  logic [SCNT_W-1:0]   set_cnt;
  logic [ACNT_W-1:0]   avg_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ADC_WDTH-1:0] result;
  logic [ADC_WDTH-1:0] out_data_q;
  logic [CH_WDTH-1:0]  out_ch_q;
  logic                out_valid_q;
  logic                overrun_q;
  logic [CH_WDTH-1:0]  pick;
  logic                found;
  logic                fire;
  logic                last_settle;

  sd_rr_pick #(
    .NUM_CH  (NUM_CH),
    .CH_WDTH (CH_WDTH)
  ) u_pick (
    .mask  (bus.ch_mask),
    .ptr   (ptr),
    .pick  (pick),
    .found (found)
  );

  // acc is wide enough for 2**AVG_LOG2 full-scale samples, so no wrap.
  always_comb begin
    acc_next    = acc + ACC_W'(bus.adc_output);
    result      = ADC_WDTH'(acc_next >> AVG_LOG2);
    fire        = (state == ACCUM) && bus.en && bus.adc_valid &&
                  (int'(avg_cnt) == AVG_N - 1);
    last_settle = (int'(set_cnt) == SETTLE - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= CH_WDTH'(NUM_CH - 1);
      mux_sel_q   <= '0;
      set_cnt     <= '0;
      avg_cnt     <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && |bus.ch_mask) state <= SELECT;
        end
        SELECT: begin
          if (!bus.en || !found) begin
            state <= IDLE;
          end else begin
            mux_sel_q <= pick;
            ptr       <= pick;
            set_cnt   <= '0;
            avg_cnt   <= '0;
            acc       <= '0;
            state     <= (SETTLE == 0) ? ACCUM : sigma_delta_pkg::SETTLE;
          end
        end
        sigma_delta_pkg::SETTLE: begin
          if (!bus.en) begin
            state <= IDLE;
          end else if (bus.adc_valid) begin
            if (last_settle) state <= ACCUM;
            else             set_cnt <= set_cnt + 1'b1;
          end
        end
        ACCUM: begin
          // Abort leaves mux_sel and ptr on the aborted channel; acc is
          // cleared on the next SELECT.
          if (!bus.en) begin
            state <= IDLE;
          end else if (bus.adc_valid) begin
            if (fire) begin
              state <= SELECT;
            end else begin
              acc     <= acc_next;
              avg_cnt <= avg_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A result arriving while the held one is not being taken is lost.
      if (fire) begin
        if (!out_valid_q || bus.out_ready) begin
          out_data_q  <= result;
          out_ch_q    <= mux_sel_q;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sigma_delta_mux_scheduler.sv
// Self-checking bench: mux model drives adc_output from mux_sel, results are
// predicted from a round-robin pointer and plain sample averaging.
module tb_sigma_delta_mux_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sigma_delta_mux_scheduler_if #(.NUM_CH(4), .ADC_WDTH(16)) sif ();

  sigma_delta_mux_scheduler #(
    .NUM_CH(4), .ADC_WDTH(16), .SETTLE(2), .AVG_LOG2(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_ptr = 3;

  // Next enabled channel after p, wrapping, p itself last.
  function automatic int rr_next(input logic [3:0] m, input int p);
    for (int k = 1; k <= 4; k++)
      if (((m >> ((p + k) % 4)) & 4'b0001) != 4'b0000) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] mux_val(input int ch);
    return 16'((ch + 1) * 32'h1000);
  endfunction

  task automatic tick_gap();
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] v);
    sif.adc_output = v;
    sif.adc_valid  = 1'b1;
    @(negedge clk);
    sif.adc_valid  = 1'b0;
    sif.adc_output = 16'(($urandom));
  endtask

  task automatic start(input logic [3:0] m, input logic rdy);
    rst = 1'b1; sif.en = 1'b0; sif.adc_valid = 1'b0;
    sif.ch_mask = m; sif.out_ready = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b0; exp_ptr = 3; sif.en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One full conversion: 2 discarded samples then 4 averaged ones.
  // Returns at the negedge right after the last averaged sample is taken.
  task automatic run_conv(input logic [3:0][15:0] smp, input bit use_mux,
                          output int ch, output logic [15:0] exp);
    logic [17:0] sum;
    logic [15:0] v;
    ch = rr_next(sif.ch_mask, exp_ptr);
    exp_ptr = ch;
    sum = '0;
    tick_gap();
    cmp_cnt++;
    if (sif.mux_sel !== 2'(ch)) begin
      err_cnt++;
      $display("FAIL conv_mux_sel: got %0d want %0d", sif.mux_sel, ch);
    end
    repeat (2) begin pulse(16'($urandom)); tick_gap(); end
    for (int i = 0; i < 4; i++) begin
      v = use_mux ? mux_val(int'(sif.mux_sel)) : smp[i];
      sum += 18'(v);
      pulse(v);
      if (i != 3) tick_gap();
    end
    exp = use_mux ? mux_val(ch) : sum[17:2];
  endtask

  task automatic test_reset();
    rst = 1'b1; sif.en = 1'b1; sif.ch_mask = 4'b1111;
    sif.adc_valid = 1'b1; sif.adc_output = 16'h1234; sif.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({sif.out_valid, sif.out_ch, sif.out_data, sif.mux_sel, sif.overrun, sif.busy} !== 22'b0) begin
        err_cnt++;
        $display("FAIL reset_state cyc%0d: got v=%0b ch=%0d d=%h sel=%0d ovr=%0b busy=%0b want all 0",
                 c, sif.out_valid, sif.out_ch, sif.out_data, sif.mux_sel, sif.overrun, sif.busy);
      end
    end
    sif.adc_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int ch; logic [15:0] exp;
    start(4'b1111, 1'b1);
    for (int j = 0; j < 5; j++) begin
      run_conv('0, 1'b1, ch, exp);
      cmp_cnt++;
      if ({sif.out_valid, sif.out_ch, sif.out_data} !== {1'b1, 2'(ch), exp}) begin
        err_cnt++;
        $display("FAIL rr_result%0d: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 j, sif.out_valid, sif.out_ch, sif.out_data, ch, exp);
      end
      @(negedge clk);
      cmp_cnt++;
      if (sif.out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL rr_accept%0d: out_valid got %0b want 0", j, sif.out_valid);
      end
    end
  endtask

  task automatic test_mask();
    int ch; logic [15:0] exp;
    start(4'b0101, 1'b1);
    for (int j = 0; j < 4; j++) begin
      run_conv('0, 1'b1, ch, exp);
      cmp_cnt++;
      if ({sif.out_valid, sif.out_ch, sif.out_data} !== {1'b1, 2'(ch), exp} || sif.mux_sel[0] !== 1'b0) begin
        err_cnt++;
        $display("FAIL mask_result%0d: got v=%0b ch=%0d d=%h sel=%0d want v=1 ch=%0d d=%h even sel",
                 j, sif.out_valid, sif.out_ch, sif.out_data, sif.mux_sel, ch, exp);
      end
    end
  endtask

  task automatic test_average();
    int ch; logic [15:0] exp;
    logic [3:0][15:0] smp;
    start(4'b0001, 1'b1);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      smp = {16'd6, 16'd3, 16'd2, 16'd1};
      else if (j == 1) smp = {4{16'hFFFF}};
      else             smp = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      run_conv(smp, 1'b0, ch, exp);
      cmp_cnt++;
      if ({sif.out_valid, sif.out_ch, sif.out_data} !== {1'b1, 2'(ch), exp}) begin
        err_cnt++;
        $display("FAIL avg_result%0d: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 j, sif.out_valid, sif.out_ch, sif.out_data, ch, exp);
      end
      // Mask only matters at the next SELECT, which is the coming edge.
      if (j >= 1) sif.ch_mask = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic test_overrun();
    int ch; logic [15:0] exp0, exp;
    start(4'b1111, 1'b0);
    run_conv('0, 1'b1, ch, exp0);
    cmp_cnt++;
    if ({sif.out_valid, sif.out_ch, sif.out_data, sif.overrun} !== {1'b1, 2'(ch), exp0, 1'b0}) begin
      err_cnt++;
      $display("FAIL ovr_first: got v=%0b ch=%0d d=%h ovr=%0b want v=1 ch=%0d d=%h ovr=0",
               sif.out_valid, sif.out_ch, sif.out_data, sif.overrun, ch, exp0);
    end
    run_conv('0, 1'b1, ch, exp);
    cmp_cnt++;
    if ({sif.out_valid, sif.out_ch, sif.out_data, sif.overrun} !== {1'b1, 2'd0, exp0, 1'b1}) begin
      err_cnt++;
      $display("FAIL ovr_held: got v=%0b ch=%0d d=%h ovr=%0b want v=1 ch=0 d=%h ovr=1",
               sif.out_valid, sif.out_ch, sif.out_data, sif.overrun, exp0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({sif.out_valid, sif.overrun} !== 2'b01) begin
      err_cnt++;
      $display("FAIL ovr_sticky: got v=%0b ovr=%0b want v=0 ovr=1", sif.out_valid, sif.overrun);
    end
    run_conv('0, 1'b1, ch, exp);
    cmp_cnt++;
    if ({sif.out_valid, sif.out_ch, sif.out_data, sif.overrun} !== {1'b1, 2'(ch), exp, 1'b1}) begin
      err_cnt++;
      $display("FAIL ovr_resume: got v=%0b ch=%0d d=%h ovr=%0b want v=1 ch=%0d d=%h ovr=1",
               sif.out_valid, sif.out_ch, sif.out_data, sif.overrun, ch, exp);
    end
    sif.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if ({sif.out_valid, sif.overrun, sif.busy, sif.mux_sel, sif.out_data} !== 21'b0) begin
      err_cnt++;
      $display("FAIL ovr_midreset: got v=%0b ovr=%0b busy=%0b sel=%0d d=%h want all 0",
               sif.out_valid, sif.overrun, sif.busy, sif.mux_sel, sif.out_data);
    end
  endtask

  task automatic test_abort();
    int ch; logic [15:0] exp;
    start(4'b1111, 1'b1);
    run_conv('0, 1'b1, ch, exp);
    @(negedge clk);
    ch = rr_next(sif.ch_mask, exp_ptr);
    exp_ptr = ch;
    tick_gap();
    repeat (2) begin pulse(16'($urandom)); tick_gap(); end
    pulse(mux_val(ch));
    tick_gap();
    sif.en = 1'b0;
    pulse(mux_val(ch));
    cmp_cnt++;
    if ({sif.busy, sif.out_valid, sif.mux_sel} !== {1'b0, 1'b0, 2'(ch)}) begin
      err_cnt++;
      $display("FAIL abort_idle: got busy=%0b v=%0b sel=%0d want busy=0 v=0 sel=%0d",
               sif.busy, sif.out_valid, sif.mux_sel, ch);
    end
    repeat (3) begin tick_gap(); pulse(16'($urandom)); end
    cmp_cnt++;
    if ({sif.busy, sif.out_valid} !== 2'b00) begin
      err_cnt++;
      $display("FAIL abort_quiet: got busy=%0b v=%0b want 0 0", sif.busy, sif.out_valid);
    end
    sif.en = 1'b1;
    repeat (2) @(negedge clk);
    run_conv('0, 1'b1, ch, exp);
    cmp_cnt++;
    if ({sif.out_valid, sif.out_ch, sif.out_data} !== {1'b1, 2'(ch), exp}) begin
      err_cnt++;
      $display("FAIL abort_resume: got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h",
               sif.out_valid, sif.out_ch, sif.out_data, ch, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sif.en = 1'b0;
    sif.ch_mask = 4'b0000;
    sif.adc_output = 16'h0000;
    sif.adc_valid = 1'b0;
    sif.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_mask();
    test_average();
    test_overrun();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
